pc_sequencer: RTL

- Registered program-counter unit that replaces the purely combinational relative-jump adder.
- Each cycle it selects the next PC from one of five sources: sequential step, PC-relative jump, absolute jump, call, or return.
- It contains a parametrised return-address stack (RAS) for call and return.
- It sits at the fetch stage and drives the instruction-memory address.

---
 rtl/pc_pkg.sv | 11 +
 rtl/pc_ras.sv | 105 ++++++++++
 rtl/pc_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared constants for the fetch-stage program counter sequencer.
// Holds the pc_mode encoding used by pc_sequencer and its testbench.
package pc_pkg;

  localparam logic [2:0] PC_SEQ  = 3'd0;
  localparam logic [2:0] PC_REL  = 3'd1;
  localparam logic [2:0] PC_ABS  = 3'd2;
  localparam logic [2:0] PC_CALL = 3'd3;
  localparam logic [2:0] PC_RET  = 3'd4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clear_i    : drop all entries (wins over push/pop)
//   push_i     : push data_i; when full, the oldest entry is overwritten
//   pop_i      : pop the top entry; no change when empty
//   top_o      : current top entry
//   full_o     : registered, count == RAS_DEPTH
//   empty_o    : registered, count == 0
//   ovf_o      : one-cycle pulse, push accepted while full
//   unf_o      : one-cycle pulse, pop accepted while empty
module pc_ras #(
  parameter int PC_W      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] data_i,
  output logic [PC_W-1:0] top_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            ovf_o,
  output logic            unf_o
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [PC_W-1:0] mem_q [RAS_DEPTH];

  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_en;

  // ptr_q is the next free slot; when full it also points at the
  // oldest entry, so a push naturally overwrites it.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    wr_en = 1'b0;
    if (clear_i) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (push_i) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PW'(1);
      if (full_q) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (pop_i) begin
      if (empty_q) begin
        unf_d = 1'b1;
      end else begin
        ptr_d = ptr_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
    end
    full_d  = (cnt_d == DEPTH_C);
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage needs no reset: entries are only read while count > 0.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[ptr_q] <= data_i;
    end
  end

  assign top_o   = mem_q[ptr_q - PW'(1)];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

endmodule

// File: rtl/pc_sequencer.sv
// Registered fetch-stage PC with next-PC select and return-address stack.
// Ports: clk, rst_n (async low), stall, flush, pc_mode, jump_steps,
//   jump_target in; pc, ras_full, ras_empty, ras_ovf, ras_unf out.
// Optional: define PC_ALIGN_CHECK_EN to add the misalign output.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter int              OFF_W     = 32,
  parameter int              STEP      = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic [2:0]       pc_mode,
  input  logic [OFF_W-1:0] jump_steps,
  input  logic [PC_W-1:0]  jump_target,
  output logic [PC_W-1:0]  pc,
  output logic             ras_full,
  output logic             ras_empty,
  output logic             ras_ovf,
  output logic             ras_unf
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             misalign
`endif
);

  localparam logic [PC_W-1:0] STEP_W = PC_W'(STEP);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] rel_pc;
  logic [PC_W-1:0] ras_top;
  logic            push;
  logic            pop;

  // Offset is sign-extended when narrower than the PC, truncated when wider.
  generate
    if (OFF_W >= PC_W) begin : g_trunc
      assign off_ext = jump_steps[PC_W-1:0];
    end else begin : g_sext
      assign off_ext = {{(PC_W-OFF_W){jump_steps[OFF_W-1]}}, jump_steps};
    end
  endgenerate

  assign seq_pc = pc_q + STEP_W;
  assign rel_pc = pc_q + off_ext;

  always_comb begin
    pc_d = pc_q;
    push = 1'b0;
    pop  = 1'b0;
    if (flush) begin
      pc_d = jump_target;
    end else if (!stall) begin
      case (pc_mode)
        PC_REL:  pc_d = rel_pc;
        PC_ABS:  pc_d = jump_target;
        PC_CALL: begin
          push = 1'b1;
          pc_d = rel_pc;
        end
        PC_RET: begin
          pop  = 1'b1;
          pc_d = ras_empty ? seq_pc : ras_top;
        end
        default: pc_d = seq_pc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (seq_pc),
    .top_o   (ras_top),
    .full_o  (ras_full),
    .empty_o (ras_empty),
    .ovf_o   (ras_ovf),
    .unf_o   (ras_unf)
  );

  assign pc = pc_q;

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q;
  logic loading;

  // Flags only PCs actually loaded this cycle; a stalled hold is silent.
  assign loading = flush | ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= loading && ((pc_d % STEP_W) != '0);
    end
  end

  assign misalign = misalign_q;
`endif

endmodule
